// File: rtl/sarlock_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sarlock_key_loader_if
// Description : Serial key-frame handshake bundle between the key source
//               (master) and the SARLock key loader (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sarlock_key_loader_if;
    logic load_start;   // one-cycle request to begin a new frame
    logic bit_valid;    // serial bit offered
    logic bit_data;     // serial bit value
    logic bit_ready;    // loader accepts a bit this cycle

    modport master (
        output load_start,
        output bit_valid,
        output bit_data,
        input  bit_ready
    );

    modport slave (
        input  load_start,
        input  bit_valid,
        input  bit_data,
        output bit_ready
    );
endinterface
`default_nettype wire

// File: rtl/sarlock_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : sarlock_key_loader
// Description : Receives a serial even-parity key frame (LSB first) and
//               drives the SARLock-locked circuit's key bus in parallel only
//               after a parity-checked commit. Consecutive bad frames latch a
//               lockout that only reset clears. KEY_W must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sarlock_key_loader #(
    parameter int KEY_W    = 24,
    parameter int MAX_FAIL = 3
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    sarlock_key_loader_if.slave                  bus,
    output logic [KEY_W-1:0]                     key_out,
    output logic                                 key_loaded,
    output logic                                 load_err,
    output logic [$clog2(MAX_FAIL+1)-1:0]        fail_cnt,
    output logic                                 lockout
);

    localparam int CNT_W  = $clog2(KEY_W + 2);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    // Counter value while the parity bit (the last bit of a frame) arrives.
    localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(KEY_W);
    localparam logic [FAIL_W-1:0] c_MAX_FAIL = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_CHECK   = 3'd2,
        S_ARMED   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [KEY_W-1:0]    r_shadow;
    logic                r_par;
    logic [KEY_W-1:0]    r_key;
    logic                r_loaded;
    logic                r_err;
    logic [FAIL_W-1:0]   r_fail;
    logic                r_lock;

    logic                w_ready;
    logic                w_accept;
    logic [KEY_W-1:0]    w_shadow_next;
    logic [FAIL_W-1:0]   w_fail_next;

    // Ready depends only on the registered state, never on load_start.
    assign w_ready       = (r_state == S_SHIFT);
    assign w_accept      = w_ready && bus.bit_valid;
    // LSB-first frame: each new bit enters at the top and moves down, so the
    // first key bit ends up in bit 0 after KEY_W shifts.
    assign w_shadow_next = {bus.bit_data, r_shadow[KEY_W-1:1]};
    // Failure count saturates at MAX_FAIL.
    assign w_fail_next   = (r_fail == c_MAX_FAIL) ? r_fail : r_fail + FAIL_W'(1);

    assign bus.bit_ready = w_ready;
    assign key_out       = r_key;
    assign key_loaded    = r_loaded;
    assign load_err      = r_err;
    assign fail_cnt      = r_fail;
    assign lockout       = r_lock;

    // Frame reception, parity check, key commit and lockout control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_par    <= 1'b0;
            r_key    <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
            r_fail   <= '0;
            r_lock   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE, S_ARMED: begin
                    // The committed key (if any) stays on the bus during reload.
                    if (bus.load_start) begin
                        r_cnt    <= '0;
                        r_par    <= 1'b0;
                        r_shadow <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.load_start) begin
                        // Restart wins over a bit handshaking in the same cycle.
                        r_cnt    <= '0;
                        r_par    <= 1'b0;
                        r_shadow <= '0;
                    end else if (w_accept) begin
                        r_par <= r_par ^ bus.bit_data;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_LAST_CNT) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_shadow <= w_shadow_next;
                        end
                    end
                end
                S_CHECK: begin
                    // r_par now holds the XOR of all key bits plus parity bit.
                    if (!r_par) begin
                        r_key    <= r_shadow;
                        r_loaded <= 1'b1;
                        r_fail   <= '0;
                        r_state  <= S_ARMED;
                    end else begin
                        r_err  <= 1'b1;
                        r_fail <= w_fail_next;
                        if (w_fail_next == c_MAX_FAIL) begin
                            r_key    <= '0;
                            r_loaded <= 1'b0;
                            r_lock   <= 1'b1;
                            r_state  <= S_LOCKOUT;
                        end else if (r_loaded) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_LOCKOUT: begin
                    r_state <= S_LOCKOUT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
